// File: rtl/player_hit_ctrl_if.sv
// Signal bundle between player_hit_ctrl and its neighbours: collision detectors,
// lives counter, restart key, player sprite and player movement logic.
interface player_hit_ctrl_if;
  logic startOfFrame;
  logic col_explosion;
  logic col_enemy;
  logic player_died;
  logic restart_req;
  logic player_hit;
  logic lives_reset;
  logic invulnerable;
  logic player_visible;
  logic freeze_player;
  logic game_over;

  // The game side drives the raw events and consumes the control outputs.
  modport master (
    output startOfFrame, col_explosion, col_enemy, player_died, restart_req,
    input  player_hit, lives_reset, invulnerable, player_visible,
           freeze_player, game_over
  );

  modport slave (
    input  startOfFrame, col_explosion, col_enemy, player_died, restart_req,
    output player_hit, lives_reset, invulnerable, player_visible,
           freeze_player, game_over
  );
endinterface

// File: rtl/player_hit_ctrl.sv
// Player hit / invulnerability / death / restart sequencer with registered outputs.
// Optional sprite blinking during invulnerability: define PLAYER_HIT_BLINK_EN.
module player_hit_ctrl #(
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_PERIOD  = 8,
  parameter int DEATH_FRAMES  = 90
) (
  input logic              clk,
  input logic              resetN,
  player_hit_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ALIVE,
    INVULN,
    DYING,
    GAME_OVER,
    RESPAWN
  } state_t;

  localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES);
  localparam logic [7:0] DEATH_LOAD  = 8'(DEATH_FRAMES);

`ifdef PLAYER_HIT_BLINK_EN
  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_PERIOD - 1);
  localparam logic       ENTRY_VIS   = 1'b0;
`else
  localparam logic       ENTRY_VIS   = 1'b1;
`endif

  state_t     state;
  logic [7:0] frame_cnt;
`ifdef PLAYER_HIT_BLINK_EN
  logic [7:0] blink_cnt;
`endif
  logic       restart_prev;

  logic collision;
  logic restart_rise;

  assign collision    = bus.col_explosion | bus.col_enemy;
  assign restart_rise = bus.restart_req & ~restart_prev;

  // NOTE: every register here uses <= so each branch sees last-cycle values and
  // the pulse defaults at the top are cleanly overridden later in the block.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state              <= ALIVE;
      frame_cnt          <= '0;
`ifdef PLAYER_HIT_BLINK_EN
      blink_cnt          <= '0;
`endif
      restart_prev       <= 1'b0;
      bus.player_hit     <= 1'b0;
      bus.lives_reset    <= 1'b0;
      bus.invulnerable   <= 1'b0;
      bus.player_visible <= 1'b1;
      bus.freeze_player  <= 1'b0;
      bus.game_over      <= 1'b0;
    end else begin
      bus.player_hit  <= 1'b0;
      bus.lives_reset <= 1'b0;
      restart_prev    <= bus.restart_req;

      unique case (state)
        ALIVE: begin
          if (bus.player_died) begin
            state              <= DYING;
            frame_cnt          <= DEATH_LOAD;
            bus.freeze_player  <= 1'b1;
            bus.player_visible <= 1'b1;
          end else if (collision) begin
            state              <= INVULN;
            frame_cnt          <= INVULN_LOAD;
`ifdef PLAYER_HIT_BLINK_EN
            blink_cnt          <= '0;
`endif
            bus.player_hit     <= 1'b1;
            bus.invulnerable   <= 1'b1;
            bus.player_visible <= ENTRY_VIS;
          end
        end

        INVULN: begin
          if (bus.player_died) begin
            state              <= DYING;
            frame_cnt          <= DEATH_LOAD;
            bus.invulnerable   <= 1'b0;
            bus.freeze_player  <= 1'b1;
            bus.player_visible <= 1'b1;
          end else if (bus.startOfFrame) begin
            if (frame_cnt == 8'd1) begin
              state              <= ALIVE;
              bus.invulnerable   <= 1'b0;
              bus.player_visible <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt - 8'd1;
`ifdef PLAYER_HIT_BLINK_EN
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt          <= '0;
                bus.player_visible <= ~bus.player_visible;
              end else begin
                blink_cnt <= blink_cnt + 8'd1;
              end
`endif
            end
          end
        end

        DYING: begin
          if (bus.startOfFrame) begin
            if (frame_cnt == 8'd1) begin
              state              <= GAME_OVER;
              bus.game_over      <= 1'b1;
              bus.player_visible <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt - 8'd1;
            end
          end
        end

        GAME_OVER: begin
          // Edge-detect so a key still held from play cannot skip the screen.
          if (restart_rise) begin
            state           <= RESPAWN;
            bus.lives_reset <= 1'b1;
            bus.game_over   <= 1'b0;
          end
        end

        RESPAWN: begin
          // player_died clears only after the lives counter applied the reload.
          if (!bus.player_died) begin
            state              <= INVULN;
            frame_cnt          <= INVULN_LOAD;
`ifdef PLAYER_HIT_BLINK_EN
            blink_cnt          <= '0;
`endif
            bus.invulnerable   <= 1'b1;
            bus.freeze_player  <= 1'b0;
            bus.player_visible <= ENTRY_VIS;
          end
        end

        default: begin
          state              <= ALIVE;
          bus.invulnerable   <= 1'b0;
          bus.freeze_player  <= 1'b0;
          bus.game_over      <= 1'b0;
          bus.player_visible <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_hit_ctrl.sv
// Scoreboard bench for player_hit_ctrl: directed stimulus queues expected output
// vectors; a monitor compares on every output pulse or explicit probe.
module tb_player_hit_ctrl;

  typedef struct {
    string      name;
    logic [5:0] outs;   // {player_hit, lives_reset, invulnerable, visible, freeze, game_over}
  } exp_t;

`ifdef PLAYER_HIT_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  localparam logic [5:0] V_RESET = 6'b000100;
  localparam logic [5:0] V_DYING = 6'b000110;
  localparam logic [5:0] V_GOVER = 6'b000011;
  localparam logic [5:0] V_RSPWN = 6'b010010;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic probe = 1'b0;

  exp_t       q[$];
  exp_t       e;
  logic [5:0] got;
  int         n_cmp = 0;
  int         n_err = 0;
  logic       vis_after [1:3];

  player_hit_ctrl_if bus ();

  player_hit_ctrl #(
    .INVULN_FRAMES(4),
    .BLINK_PERIOD (2),
    .DEATH_FRAMES (3)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] v_inv(input logic vis);
    return {1'b0, 1'b0, 1'b1, vis, 1'b0, 1'b0};
  endfunction

  function automatic logic [5:0] v_hit();
    return {1'b1, 1'b0, 1'b1, ~BLINK, 1'b0, 1'b0};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input string name, input logic [5:0] outs);
    exp_t x;
    x.name = name;
    x.outs = outs;
    q.push_back(x);
  endtask

  task automatic check(input string name, input logic [5:0] outs);
    push_exp(name, outs);
    probe = 1'b1;
    tick(1);
    probe = 1'b0;
  endtask

  task automatic frame();
    bus.startOfFrame = 1'b1;
    tick(1);
    bus.startOfFrame = 1'b0;
    tick(2);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  // Monitor: one pop per negedge when a pulse or probe is present.
  initial begin
    forever begin
      @(negedge clk);
      got = {bus.player_hit, bus.lives_reset, bus.invulnerable,
             bus.player_visible, bus.freeze_player, bus.game_over};
      if (got[5] === 1'b1 || got[4] === 1'b1 || probe) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got %b, nothing expected", got);
        end else begin
          e = q.pop_front();
          if (got !== e.outs) begin
            n_err++;
            $display("FAIL %s: got %b want %b", e.name, got, e.outs);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: got no finish, want finish before 200000");
    summary();
    $finish;
  end

  initial begin
    vis_after[1] = BLINK ? 1'b0 : 1'b1;
    vis_after[2] = 1'b1;
    vis_after[3] = 1'b1;

    bus.startOfFrame  = 1'b0;
    bus.col_explosion = 1'b0;
    bus.col_enemy     = 1'b0;
    bus.player_died   = 1'b0;
    bus.restart_req   = 1'b0;
    tick(2);
    resetN = 1'b1;
    check("reset", V_RESET);

    // Held collision gives one hit; a second collision mid-window is ignored.
    push_exp("hit_held", v_hit());
    bus.col_enemy = 1'b1;
    tick(20);
    bus.col_enemy = 1'b0;
    check("invuln_entry", v_inv(~BLINK));
    for (int f = 1; f <= 3; f++) begin
      frame();
      check($sformatf("invuln_frame%0d", f), v_inv(vis_after[f]));
      if (f == 1) begin
        bus.col_explosion = 1'b1;
        tick(3);
        bus.col_explosion = 1'b0;
      end
    end
    frame();
    check("alive_after_invuln", V_RESET);

    // Fresh hit right after ALIVE, then death one cycle after the hit.
    push_exp("hit_again", v_hit());
    bus.col_enemy = 1'b1;
    tick(1);
    bus.col_enemy = 1'b0;
    tick(1);
    bus.player_died = 1'b1;
    tick(1);
    check("dying_entry", V_DYING);
    frame();
    frame();
    check("dying_frame2", V_DYING);
    bus.restart_req = 1'b1;
    frame();
    check("game_over", V_GOVER);
    tick(4);
    check("held_key_no_restart", V_GOVER);

    // Release then press: one lives_reset, then spawn protection.
    bus.restart_req = 1'b0;
    tick(2);
    push_exp("lives_reset", V_RSPWN);
    bus.restart_req = 1'b1;
    tick(1);
    bus.player_died = 1'b0;
    tick(1);
    bus.restart_req = 1'b0;
    check("respawn_invuln", v_inv(~BLINK));
    for (int f = 1; f <= 3; f++) begin
      frame();
      check($sformatf("respawn_frame%0d", f), v_inv(vis_after[f]));
    end
    frame();
    check("alive_after_respawn", V_RESET);

    // Collision coincident with a frame pulse: that pulse is not counted.
    push_exp("hit_with_sof", v_hit());
    bus.col_enemy    = 1'b1;
    bus.startOfFrame = 1'b1;
    tick(1);
    bus.col_enemy    = 1'b0;
    bus.startOfFrame = 1'b0;
    tick(1);
    frame();
    frame();
    frame();
    check("sof_not_counted", v_inv(vis_after[3]));
    frame();
    check("alive_after_sof_hit", V_RESET);

    // Death coincident with collision: DYING, no hit pulse.
    bus.player_died = 1'b1;
    bus.col_enemy   = 1'b1;
    tick(1);
    bus.col_enemy   = 1'b0;
    check("died_beats_hit", V_DYING);

    // Asynchronous reset in DYING.
    resetN = 1'b0;
    bus.player_died = 1'b0;
    check("reset_in_dying", V_RESET);
    resetN = 1'b1;
    tick(1);
    check("alive_after_reset", V_RESET);
    push_exp("hit_after_reset", v_hit());
    bus.col_explosion = 1'b1;
    tick(1);
    bus.col_explosion = 1'b0;
    tick(3);

    while (q.size() != 0) begin
      e = q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no output, want %b", e.name, e.outs);
    end
    summary();
    $finish;
  end

endmodule

// File: doc/player_hit_ctrl.md
# player_hit_ctrl

Converts raw player collision levels into the single-cycle `player_hit` pulses that drive the lives counter, and consumes that counter's `player_died` flag. It enforces a post-hit invulnerability window with sprite blinking and runs the death → game-over → restart sequence. On restart it issues the `lives_reset` pulse back to the lives counter. It sits between the collision detectors and the lives counter, and feeds the player sprite and player movement logic.

## Interface
- `INVULN_FRAMES`, default 120: frames of invulnerability after a hit or respawn; legal range 1..255.
- `BLINK_PERIOD`, default 8: frames per visibility toggle during invulnerability; legal range 1..255.
- `DEATH_FRAMES`, default 90: frames spent in the death animation before game over; legal range 1..255.

Ports (reset resetN, asynchronous, active-low; clock clk):
- `clk`  in  1  system clock
- `resetN`  in  1  asynchronous, active-low reset
- `startOfFrame`  in  1  one-cycle pulse per video frame
- `col_explosion`  in  1  level; player overlaps a bomb explosion
- `col_enemy`  in  1  level; player overlaps an enemy
- `player_died`  in  1  level from the lives counter (lives == 0)
- `restart_req`  in  1  level from the restart key
- `player_hit`  out  1  one-cycle pulse; decrement one life
- `lives_reset`  out  1  one-cycle pulse; reload lives
- `invulnerable`  out  1  high in INVULN
- `player_visible`  out  1  sprite enable / blink mask
- `freeze_player`  out  1  blocks player movement
- `game_over`  out  1  high in GAME_OVER

## Operation
- FSM states: ALIVE, INVULN, DYING, GAME_OVER, RESPAWN.
- All outputs are registered.
- Reset values: state = ALIVE; `player_hit` = 0, `lives_reset` = 0, `invulnerable` = 0, `freeze_player` = 0, `game_over` = 0, `player_visible` = 1; all counters = 0; `restart_prev` = 0.
- ALIVE:
  - `player_died` = 1 → DYING. This has the highest priority and covers a debug-switch decrement to 0.
  - Else (`col_explosion` | `col_enemy`) → set `player_hit` = 1 for one cycle, load `frame_cnt` = `INVULN_FRAMES`, clear `blink_cnt`, → INVULN.
- INVULN:
  - Collisions are ignored.
  - `player_died` = 1 → DYING (priority).
  - On each `startOfFrame`: if `frame_cnt` == 1 → ALIVE with `player_visible` = 1; else decrement `frame_cnt`.
  - Net effect: exactly `INVULN_FRAMES` frame pulses are spent in INVULN.
- Blink (INVULN only):
  - On entry, `player_visible` = 0.
  - `blink_cnt` counts `startOfFrame` pulses; when `blink_cnt` == `BLINK_PERIOD`-1, toggle `player_visible` and clear `blink_cnt`.
- DYING:
  - `freeze_player` = 1, `player_visible` = 1.
  - On entry, `frame_cnt` = `DEATH_FRAMES`; decrement per `startOfFrame`; at 1 → GAME_OVER.
- GAME_OVER:
  - `game_over` = 1, `freeze_player` = 1, `player_visible` = 0.
  - A rising edge of `restart_req` (`restart_req` & !`restart_prev`) → set `lives_reset` = 1 for one cycle, → RESPAWN.
- RESPAWN:
  - `freeze_player` = 1, `game_over` = 0.
  - Waits until `player_died` == 0, then loads `frame_cnt` = `INVULN_FRAMES`, → INVULN (spawn protection).
- `restart_prev` samples `restart_req` every cycle in every state. A key already held when GAME_OVER is entered does not trigger a restart.
- Counters are 8 bits unsigned and never wrap: a load always precedes any decrement, and the exit condition is checked at 1.

## Timing
- Collision sampled at edge N (state ALIVE) → `player_hit` high for cycle N..N+1 only; `invulnerable` high from edge N.
- Lives counter updates at edge N+1. `player_died` may rise then; it is seen at edge N+2 → DYING.
- Collision held high for many cycles produces exactly one `player_hit` per INVULN window.
- Collision coincident with `startOfFrame` in ALIVE: the hit is taken and the frame pulse is not counted.
- `player_died` coincident with a collision in ALIVE: DYING is taken and no `player_hit` is issued.
- `lives_reset` is high for exactly one cycle. RESPAWN lasts at least one cycle, so the lives counter's reload settles before the exit condition is checked.
- `resetN` asserted mid-sequence returns to reset values immediately (asynchronous). Any pending pulse is dropped.

## Configuration
- `PLAYER_HIT_BLINK_EN` defined: blink behaviour in INVULN as specified above.
- Undefined: `player_visible` = 1 throughout INVULN and `blink_cnt` logic is removed. All other states are unchanged.

## Test plan
All scenarios use `INVULN_FRAMES`=4, `BLINK_PERIOD`=2, `DEATH_FRAMES`=3.
- After reset, `col_enemy` held 20 cycles → one `player_hit` pulse; `invulnerable` = 1; state returns to ALIVE on the 4th subsequent `startOfFrame`.
- With blink enabled, `player_visible` sequence per frame in INVULN is 0,0,1,1, then 1 on ALIVE. With `PLAYER_HIT_BLINK_EN` undefined, `player_visible` stays 1.
- Second collision at frame 2 of INVULN → no `player_hit`. A collision 1 cycle after returning to ALIVE → a new pulse.
- `player_died` raised 1 cycle after a hit → DYING; `freeze_player` = 1; after 3 frames `game_over` = 1 and `player_visible` = 0.
- `restart_req` held high while entering GAME_OVER → no `lives_reset`. Release then press → one `lives_reset` pulse; with `player_died` dropping 1 cycle later → INVULN for 4 frames, then ALIVE.
- `resetN` pulsed low in DYING → all outputs at reset values and state ALIVE on the next cycle.
